dealer_control: RTL
===================

# dealer_control

Central game sequencer for the poker table. It walks every seated player through the deal, bet, sort, send, receive and settle phases by driving the shared `state`/`pid`/`ack` bus. It collects each player's acknowledge, fold flag and chip offer, and accumulates the pot. At the end of a hand it announces the winner and pulses `game_over`. It sits directly upstream of every player controller and is the sole master of the phase bus.

## Interface
- `NUM_PLAYERS`, 6: seated players, ids 1..NUM_PLAYERS (max 7)
- `CARDS_PER_HAND`, 5: card acks required per player in DEAL
- `ACK_TIMEOUT`, 16: cycles a player may take to answer a request
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin a hand; honoured only in IDLE
- `player_ack`  in  1  acknowledge from the addressed player
- `player_done`  in  1  with `player_ack`: last transfer of SEND/RECV for this player
- `player_fold`  in  1  with `player_ack`: addressed player folds
- `player_chipsel`  in  1  with `player_ack`: `player_chip` is valid
- `player_chip`  in  8  chips offered to pot
- `winner_in`  in  3  winner id from hand evaluator
- `winner_valid`  in  1  `winner_in` valid
- `state`  out  3  phase bus to players
- `pid`  out  3  addressed player, 0 = none
- `ack_out`  out  1  request strobe to addressed player
- `game_over`  out  1  one-cycle end-of-hand pulse
- `winner`  out  3  registered winner id
- `pot`  out  8  accumulated pot
- `timeout_err`  out  1  one-cycle pulse on player timeout

## Operation
- Phase encoding on `state`: DEAL 000, BET 001, SORT 010, SEND 011, RECV 100, SETTLE 101, IDLE 111.
- Reset values: state=111, pid=0, ack_out=0, game_over=0, winner=0, pot=0, timeout_err=0, fold mask=0.
- Reset mid-hand aborts the hand. The pot is discarded and the block returns to IDLE.
- IDLE + `start`: fold mask cleared, pot cleared, enter DEAL with pid=1.
- Per-player slot: raise `ack_out` and wait for `player_ack`. An ack is counted only while `ack_out`=1. After each ack, `ack_out` goes low for exactly one cycle before the next request.
- DEAL: CARDS_PER_HAND acks per player, then pid+1.
- BET: one ack per player. If `player_fold`, set fold bit. Else if `player_chipsel`, pot += `player_chip`.
- SORT: one ack per active player.
- SEND, RECV: repeated acks until an ack arrives with `player_done`=1, then next player. In RECV, the done ack also samples fold and chip as in BET.
- Folded players are skipped: pid jumps to the next unfolded id with no request issued.
- After the last pid of a phase, move to the next phase with pid = lowest active id.
- After BET, if ≤1 player is active, jump directly to SETTLE.
- SETTLE: pid=0, ack_out=0. Wait for `winner_valid`, then latch `winner`, pulse `game_over` for one cycle, and go to IDLE. `pot` holds its value until the next `start`.
- Pot arithmetic: 9-bit sum, saturating at 8'hFF.
- `start` outside IDLE is ignored.

## Timing
- All outputs are registered.
- `state`/`pid` change on the same edge that begins the first request of a slot.
- Ack sampled on cycle N → `ack_out`=0 at N+1 → next request `ack_out`=1 at N+2.
- `player_ack` together with a timeout expiry on the same cycle: the ack wins.
- Minimum DEAL duration for 6 players is 6·5·2 = 60 cycles.

## Configuration
- `DEALER_TIMEOUT_EN` defined: if no ack arrives within ACK_TIMEOUT cycles of `ack_out` rising, the player is marked folded, `timeout_err` pulses for one cycle, and the slot advances.
- Not defined: the dealer waits indefinitely and `timeout_err` is tied to 0.

## Structure
- `poker_pkg`: phase enum (3-bit encodings above), `PID_NONE`, `MAX_PLAYERS`, chip width constant. These are shared with the player controllers.
- Sub-module `dealer_watchdog`: loadable down-counter with start/clear/expired. Instantiated only under `DEALER_TIMEOUT_EN`.

## Test plan
- Reset, then `start`; players ack immediately → state walks 000→001→010→011→100→101; 30 DEAL acks observed; pid sequence 1..6 in each phase.
- BET: players 1–6 offer 8'h10 each, none fold → pot=8'h60 at end of BET.
- BET: players 2–6 fold → jump to SETTLE after BET. `winner_valid` with `winner_in`=1 → `winner`=1, `game_over` high for exactly 1 cycle, then state=111.
- BET offers 8'hF0 and 8'h20 → pot saturates at 8'hFF.
- With `DEALER_TIMEOUT_EN`, player 3 silent in SORT → `timeout_err` pulse 16 cycles after `ack_out` rises; player 3 is skipped in SEND/RECV.
- Reset asserted during RECV → next cycle state=111, pid=0, pot=0, ack_out=0.

Source files
------------

// File: rtl/poker_pkg.sv
// Types and helpers shared by the dealer and the player controllers:
// phase bus encoding, player id limits and fold-mask scans.
package poker_pkg;

  typedef enum logic [2:0] {
    PH_DEAL   = 3'b000,
    PH_BET    = 3'b001,
    PH_SORT   = 3'b010,
    PH_SEND   = 3'b011,
    PH_RECV   = 3'b100,
    PH_SETTLE = 3'b101,
    PH_IDLE   = 3'b111
  } phase_t;

  localparam logic [2:0] PID_NONE    = 3'd0;
  localparam int         MAX_PLAYERS = 7;
  localparam int         CHIP_W      = 8;

  function automatic phase_t next_phase(input phase_t ph);
    case (ph)
      PH_DEAL: next_phase = PH_BET;
      PH_BET:  next_phase = PH_SORT;
      PH_SORT: next_phase = PH_SEND;
      PH_SEND: next_phase = PH_RECV;
      default: next_phase = PH_SETTLE;
    endcase
  endfunction

  // Lowest unfolded id strictly above 'after', or PID_NONE when none is left.
  function automatic logic [2:0] next_active(input logic [MAX_PLAYERS:0] fold,
                                             input logic [2:0] after,
                                             input int num);
    next_active = PID_NONE;
    for (int i = MAX_PLAYERS; i >= 1; i--) begin
      if (i > int'(after) && i <= num && !fold[i]) next_active = 3'(i);
    end
  endfunction

  function automatic int active_count(input logic [MAX_PLAYERS:0] fold, input int num);
    active_count = 0;
    for (int i = 1; i <= MAX_PLAYERS; i++) begin
      if (i <= num && !fold[i]) active_count++;
    end
  endfunction

endpackage

// File: rtl/dealer_watchdog.sv
// Request watchdog: counts down while 'start' is held and flags 'expired' on the
// last cycle of the window; reloads whenever 'start' is low or 'clear' pulses.
module dealer_watchdog #(
  parameter int unsigned LOAD = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int W = (LOAD < 2) ? 1 : $clog2(LOAD + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear || !start) begin
      count <= W'(LOAD);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expired = start && (count == '0);

endmodule

// File: rtl/dealer_control.sv
// Poker table phase sequencer: sole master of the state/pid/ack bus.
// Build option DEALER_TIMEOUT_EN adds a per-request watchdog that folds silent players.
module dealer_control
  import poker_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS    = 6,
  parameter int unsigned CARDS_PER_HAND = 5,
  parameter int unsigned ACK_TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              player_ack,
  input  logic              player_done,
  input  logic              player_fold,
  input  logic              player_chipsel,
  input  logic [CHIP_W-1:0] player_chip,
  input  logic [2:0]        winner_in,
  input  logic              winner_valid,
  output logic [2:0]        state,
  output logic [2:0]        pid,
  output logic              ack_out,
  output logic              game_over,
  output logic [2:0]        winner,
  output logic [CHIP_W-1:0] pot,
  output logic              timeout_err
);

  localparam int CNT_W = (CARDS_PER_HAND < 2) ? 1 : $clog2(CARDS_PER_HAND + 1);

  phase_t                 phase;
  logic [MAX_PLAYERS:0]   fold_mask;
  logic [CNT_W-1:0]       card_cnt;
  logic                   slot_done;
  logic                   wd_expired;
  logic [2:0]             nxt_pid;
  logic [2:0]             first_pid;
  logic                   few_active;
  logic                   take_bet;
  logic [CHIP_W:0]        pot_sum;

  assign state      = phase;
  assign nxt_pid    = next_active(fold_mask, pid, NUM_PLAYERS);
  assign first_pid  = next_active(fold_mask, PID_NONE, NUM_PLAYERS);
  assign few_active = active_count(fold_mask, NUM_PLAYERS) <= 1;
  assign take_bet   = (phase == PH_BET) || (phase == PH_RECV && player_done);
  assign pot_sum    = {1'b0, pot} + {1'b0, player_chip};

`ifdef DEALER_TIMEOUT_EN
  dealer_watchdog #(
    .LOAD (ACK_TIMEOUT - 1)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .start   (ack_out),
    .clear   (player_ack),
    .expired (wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // A slot alternates request (ack_out high) and a one-cycle gap; the gap cycle
  // decides whether to re-request, move to the next player or change phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= PH_IDLE;
      pid         <= PID_NONE;
      ack_out     <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 3'd0;
      pot         <= '0;
      timeout_err <= 1'b0;
      fold_mask   <= '0;
      card_cnt    <= '0;
      slot_done   <= 1'b0;
    end else begin
      game_over   <= 1'b0;
      timeout_err <= 1'b0;
      case (phase)
        PH_IDLE: begin
          if (start) begin
            fold_mask <= '0;
            pot       <= '0;
            phase     <= PH_DEAL;
            pid       <= 3'd1;
            ack_out   <= 1'b1;
            card_cnt  <= '0;
            slot_done <= 1'b0;
          end
        end
        PH_SETTLE: begin
          pid     <= PID_NONE;
          ack_out <= 1'b0;
          if (winner_valid) begin
            winner    <= winner_in;
            game_over <= 1'b1;
            phase     <= PH_IDLE;
          end
        end
        default: begin
          if (ack_out) begin
            if (player_ack) begin
              ack_out <= 1'b0;
              case (phase)
                PH_DEAL: begin
                  if (card_cnt == CNT_W'(CARDS_PER_HAND - 1)) slot_done <= 1'b1;
                  else card_cnt <= card_cnt + CNT_W'(1);
                end
                PH_SEND, PH_RECV: slot_done <= player_done;
                default:          slot_done <= 1'b1;
              endcase
              if (take_bet) begin
                if (player_fold) begin
                  fold_mask[pid] <= 1'b1;
                end else if (player_chipsel) begin
                  pot <= pot_sum[CHIP_W] ? '1 : pot_sum[CHIP_W-1:0];
                end
              end
            end else if (wd_expired) begin
              ack_out        <= 1'b0;
              fold_mask[pid] <= 1'b1;
              timeout_err    <= 1'b1;
              slot_done      <= 1'b1;
            end
          end else if (!slot_done) begin
            ack_out <= 1'b1;
          end else begin
            slot_done <= 1'b0;
            card_cnt  <= '0;
            if (nxt_pid != PID_NONE) begin
              pid     <= nxt_pid;
              ack_out <= 1'b1;
            end else if ((phase == PH_BET && few_active) || first_pid == PID_NONE ||
                         next_phase(phase) == PH_SETTLE) begin
              phase <= PH_SETTLE;
              pid   <= PID_NONE;
            end else begin
              phase   <= next_phase(phase);
              pid     <= first_pid;
              ack_out <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
